lsu_data_memory: RTL and testbench

LSU_DATA_MEMORY -- requirements
Module: lsu_data_memory

---
 rtl/lsu_mem_pkg.sv | 19 +
 rtl/lsu_load_align.sv | 54 +++++
 rtl/lsu_data_memory.sv | 129 ++++++++++++
 tb/tb_lsu_data_memory.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_pkg.sv
// Shared definitions for the LSU data memory: access size encoding,
// FSM state type and the size-to-byte-count helper.
package lsu_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Request checking (alignment, range, legal size) and load extension.
// raw holds the XLEN/8 memory bytes starting at addr, little-endian.
module lsu_load_align
    import lsu_mem_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ADDR_W      = 64,
    parameter int DEPTH_BYTES = 256
) (
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   raw,
    output logic              err,
    output logic [XLEN-1:0]   ld_data
);

    localparam int SHW = $clog2(XLEN) + 1;

    logic [3:0]             nbytes;
    logic                   misaligned;
    logic                   bad_size;
    logic                   out_of_range;
    logic [ADDR_W:0]        end_addr;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        shifted;
    logic [XLEN-1:0]        zext;
    logic signed [XLEN-1:0] sext;

    // Error classification and extension by shifting the loaded bytes to
    // the top of the word, then shifting back logically or arithmetically.
    always_comb begin
        nbytes = size_bytes(size);
        unique case (size)
            SZ_H:    misaligned = addr[0];
            SZ_W:    misaligned = |addr[1:0];
            SZ_D:    misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
        bad_size = (XLEN == 32) && (size == SZ_D);
        // One extra bit so a wrapping address cannot land back in range.
        end_addr     = {1'b0, addr} + (ADDR_W+1)'(nbytes);
        out_of_range = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
        err          = misaligned | out_of_range | bad_size;

        if (bad_size) sh = '0;
        else          sh = SHW'(XLEN - 8 * int'(nbytes));
        shifted = raw << sh;
        zext    = shifted >> sh;
        sext    = $signed(shifted) >>> sh;
        ld_data = is_unsigned ? zext : sext;
    end

endmodule

// File: rtl/lsu_data_memory.sv
// Byte-addressed little-endian data memory with a one-deep registered
// response and valid/ready handshakes on both sides.
//
//   state   | meaning
//   --------+--------------------------------------
//   ST_IDLE | no response held
//   ST_RESP | response held in resp_rdata/resp_err
module lsu_data_memory
    import lsu_mem_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ADDR_W      = 64,
    parameter int DEPTH_BYTES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int NB = XLEN / 8;
    localparam int IW = $clog2(DEPTH_BYTES);

    logic [7:0]                  mem_q [DEPTH_BYTES] = '{default: 8'h00};
    logic [DEPTH_BYTES-1:0]      byte_we;
    logic [DEPTH_BYTES-1:0][7:0] byte_wd;

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            accept;
    logic            chk_err;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] raw;
    logic [ADDR_W:0] ridx;
    logic [ADDR_W:0] widx;
    logic [3:0]      nbytes;

    lsu_load_align #(
        .XLEN        (XLEN),
        .ADDR_W      (ADDR_W),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_align (
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .addr        (req_addr),
        .raw         (raw),
        .err         (chk_err),
        .ld_data     (ld_data)
    );

    // Gather the XLEN/8 bytes at req_addr; bytes past the end read as zero.
    always_comb begin
        raw  = '0;
        ridx = '0;
        for (int k = 0; k < NB; k++) begin
            ridx = {1'b0, req_addr} + (ADDR_W+1)'(k);
            if (ridx < (ADDR_W+1)'(DEPTH_BYTES))
                raw[8*k +: 8] = mem_q[ridx[IW-1:0]];
        end
    end

    // Per-byte write enables for an accepted, error-free store.
    always_comb begin
        byte_we = '0;
        byte_wd = '0;
        widx    = '0;
        nbytes  = size_bytes(req_size);
        if (accept && req_we && !chk_err) begin
            for (int k = 0; k < NB; k++) begin
                if (k < int'(nbytes)) begin
                    widx = {1'b0, req_addr} + (ADDR_W+1)'(k);
                    byte_we[widx[IW-1:0]] = 1'b1;
                    byte_wd[widx[IW-1:0]] = req_wdata[8*k +: 8];
                end
            end
        end
    end

    // Storage is never reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH_BYTES; i++)
            if (byte_we[i]) mem_q[i] <= byte_wd[i];
    end

    // Handshake and next-state/response computation.
    always_comb begin
        req_ready = reset | (state_q == ST_IDLE) | resp_ready;
        accept    = req_valid & req_ready & ~reset;
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        if (accept) begin
            state_d = ST_RESP;
            err_d   = chk_err;
            rdata_d = (chk_err || req_we) ? '0 : ld_data;
        end else if (state_q == ST_RESP && resp_ready) begin
            state_d = ST_IDLE;
        end
    end

    // FSM state and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed and randomized checks of lsu_data_memory against a byte-array
// reference model (XLEN=64, ADDR_W=64, DEPTH_BYTES=256).
module tb_lsu_data_memory;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  ref_mem [DEPTH];
    logic [63:0] last_d;
    logic        last_e;

    lsu_data_memory #(
        .XLEN        (64),
        .ADDR_W      (64),
        .DEPTH_BYTES (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: a request of n bytes is legal if addr is a multiple of n
    // and the last byte addr+n-1 is inside the array.
    task automatic model(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wd,
                         output logic [63:0] exp_d, output logic exp_e);
        int unsigned n;
        logic [63:0] v;
        n     = 1 << sz;
        exp_e = ((addr % n) != 0) || (addr > 64'(DEPTH - n));
        exp_d = '0;
        if (!exp_e) begin
            if (we) begin
                for (int k = 0; k < int'(n); k++) ref_mem[addr + k] = wd[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < int'(n); k++) v = v | (64'(ref_mem[addr + k]) << (8 * k));
                if (!uns && n < 8 && v[8*n-1])
                    v = v | ~((64'd1 << (8 * n)) - 64'd1);
                exp_d = v;
            end
        end
    endtask

    // One request, accepted on the next edge, response checked 1 cycle later.
    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wd);
        logic [63:0] ed;
        logic        ee;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; resp_ready = 1'b1;
        #1 check("req_ready", req_ready, 1'b1);
        model(we, sz, uns, addr, wd, ed, ee);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("resp_valid", resp_valid, 1'b1);
        check("resp_err", resp_err, ee);
        check("resp_rdata", resp_rdata, ed);
        last_d = ed;
        last_e = ee;
    endtask

    initial begin
        logic [63:0] ed;
        logic        ee;
        logic [63:0] held;
        logic [1:0]  sz;
        logic [63:0] a;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 64'h0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        @(negedge clk) reset = 1'b0;

        // Double store/load round trip
        issue(1'b1, 2'b11, 1'b0, 64'd8, 64'h8877665544332211);
        check("sd8_rdata", resp_rdata, 64'h0);
        issue(1'b0, 2'b11, 1'b0, 64'd8, 64'h0);
        check("ld8_lit", resp_rdata, 64'h8877665544332211);
        check("ld8_err", resp_err, 1'b0);

        // Byte 15 sign/zero extension
        issue(1'b0, 2'b00, 1'b0, 64'd15, 64'h0);
        check("lb15_s_lit", resp_rdata, 64'hFFFFFFFFFFFFFF88);
        issue(1'b0, 2'b00, 1'b1, 64'd15, 64'h0);
        check("lb15_u_lit", resp_rdata, 64'h0000000000000088);

        // Misaligned half store leaves bytes 2..4 untouched
        issue(1'b1, 2'b10, 1'b0, 64'd0, 64'h00000000A1A2A3A4);
        issue(1'b1, 2'b10, 1'b0, 64'd4, 64'h00000000B1B2B3B4);
        issue(1'b1, 2'b01, 1'b0, 64'd3, 64'h000000000000BEEF);
        check("sh3_err_lit", resp_err, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 64'd2, 64'h0);
        check("b2_lit", resp_rdata, 64'hA2);
        issue(1'b0, 2'b00, 1'b1, 64'd3, 64'h0);
        check("b3_lit", resp_rdata, 64'hA1);
        issue(1'b0, 2'b00, 1'b1, 64'd4, 64'h0);
        check("b4_lit", resp_rdata, 64'hB4);

        // Range edges
        issue(1'b0, 2'b10, 1'b0, 64'd252, 64'h0);
        check("lw252_err", resp_err, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 64'd256, 64'h0);
        check("lw256_err", resp_err, 1'b1);
        check("lw256_rdata", resp_rdata, 64'h0);
        issue(1'b0, 2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0);
        check("lwwrap_err", resp_err, 1'b1);

        // Backpressure: response held 3 cycles, next accept when ready returns
        issue(1'b0, 2'b11, 1'b0, 64'd8, 64'h0);
        held = last_d;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 64'd0; resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check("stall_req_ready", req_ready, 1'b0);
            @(posedge clk);
            #1;
            check("stall_valid", resp_valid, 1'b1);
            check("stall_rdata", resp_rdata, held);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1 check("unstall_req_ready", req_ready, 1'b1);
        model(1'b0, 2'b10, 1'b0, 64'd0, 64'h0, ed, ee);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("unstall_valid", resp_valid, 1'b1);
        check("unstall_rdata", resp_rdata, ed);

        // Drain with no new request: valid drops, data stays
        held = resp_rdata;
        @(negedge clk) resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_valid", resp_valid, 1'b0);
        check("drain_rdata", resp_rdata, held);

        // Reset while holding a response, with a store presented
        issue(1'b1, 2'b11, 1'b0, 64'd16, 64'h0123456789ABCDEF);
        issue(1'b0, 2'b11, 1'b0, 64'd8, 64'h0);
        @(negedge clk);
        resp_ready = 1'b0; reset = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_addr = 64'd16;
        req_wdata = 64'hDEADBEEFCAFEF00D;
        #1 check("rst_held_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        check("rst_held_valid", resp_valid, 1'b0);
        check("rst_held_rdata", resp_rdata, 64'h0);
        check("rst_held_err", resp_err, 1'b0);
        @(negedge clk) begin reset = 1'b0; req_valid = 1'b0; end
        issue(1'b0, 2'b11, 1'b0, 64'd16, 64'h0);
        check("rst_mem_lit", resp_rdata, 64'h0123456789ABCDEF);

        // Randomized traffic with occasional stalls
        for (int it = 0; it < 200; it++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, 263));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                req_valid = 1'b0; resp_ready = 1'b0;
                #1 check("rnd_stall_ready", req_ready, 1'b0);
                @(posedge clk);
                #1;
                check("rnd_stall_valid", resp_valid, 1'b1);
                check("rnd_stall_rdata", resp_rdata, last_d);
                check("rnd_stall_err", resp_err, last_e);
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom});
        end

        // Full sweep of memory against the model
        for (int i = 0; i < DEPTH; i += 8)
            issue(1'b0, 2'b11, 1'b0, 64'(i), 64'h0);

        @(negedge clk) resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
